// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage in front of the instruction memory.
// Owns the PC, drives the IM address, registers the returned word into an
// IF/ID slot with a valid/ready handshake, and stops fetching once the last
// word of instruction memory has been captured.
// Optional feature macro: FETCH_CNT_EN adds the fetch_cnt accepted-instruction counter.
module instr_fetch_unit #(
  parameter int MEM_SIZE = 128,
  parameter int RESET_PC = 0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] InstrAddr,
  input  logic [31:0] Instr,
  input  logic        redirect_en,
  input  logic [31:0] redirect_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        done
`ifdef FETCH_CNT_EN
  ,
  output logic [31:0] fetch_cnt
`endif
);

  localparam logic [31:0] MEM_END  = 32'(MEM_SIZE);
  localparam logic [31:0] LAST_PC  = 32'(MEM_SIZE - 4);
  localparam logic [31:0] RST_PC   = 32'(RESET_PC);

  typedef enum logic {S_RUN, S_DONE} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] redir_pc;
  logic        slot_free;

  // Low address bits are dropped so every PC stays word aligned.
  assign redir_pc  = redirect_addr & 32'hFFFF_FFFC;
  assign slot_free = !out_valid || out_ready;
  assign InstrAddr = pc;

  // Fetch FSM: redirect beats stall; DONE only drains the output slot.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_RUN;
      pc        <= RST_PC;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
      done      <= 1'b0;
    end else if (redirect_en) begin
      pc        <= redir_pc;
      out_valid <= 1'b0;
      if (redir_pc < MEM_END) begin
        state <= S_RUN;
        done  <= 1'b0;
      end else begin
        state <= S_DONE;
        done  <= 1'b1;
      end
    end else begin
      case (state)
        S_RUN: begin
          if (slot_free) begin
            out_instr <= Instr;
            out_pc    <= pc;
            out_valid <= 1'b1;
            // Last word: capture it, but park the PC instead of wrapping.
            if (pc == LAST_PC) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              pc <= pc + 32'd4;
            end
          end
        end
        S_DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: state <= S_RUN;
      endcase
    end
  end

`ifdef FETCH_CNT_EN
  // Count accepted instructions; a redirect cycle never counts, and the count saturates.
  always_ff @(posedge clk) begin
    if (!rst)
      fetch_cnt <= '0;
    else if (!redirect_en && out_valid && out_ready && fetch_cnt != 32'hFFFF_FFFF)
      fetch_cnt <= fetch_cnt + 32'd1;
  end
`endif

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the instruction memory: owns the program counter and drives the IM address.
- Captures the returned 32-bit instruction into an IF/ID output register and hands it to the decode stage with a valid/ready handshake.
- Supports stall (backpressure), PC redirect with flush, and end-of-program detection at the instruction memory boundary.

Parameters:
- MEM_SIZE, 128, instruction memory size in bytes; must be a multiple of 4 and at least 4.
- RESET_PC, 0, PC value loaded on reset; word aligned and less than MEM_SIZE.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-low.
- InstrAddr  output  32  address to instruction memory; combinationally equal to the PC register.
- Instr  input  32  instruction word returned by the instruction memory; combinational in the same cycle.
- redirect_en  input  1  load the PC from redirect_addr and flush the output slot.
- redirect_addr  input  32  redirect target; bits [1:0] are ignored and treated as 0.
- out_valid  output  1  the IF/ID slot holds a valid instruction.
- out_ready  input  1  decode accepts the slot this cycle.
- out_instr  output  32  registered instruction.
- out_pc  output  32  address the out_instr word was fetched from.
- done  output  1  end of program reached; fetching has stopped.

Behaviour:
- Reset (rst==0 at a rising edge):
  - PC=RESET_PC, out_valid=0, out_instr=0, out_pc=0, done=0.
  - State=RUN.
  - Reset overrides every other input, including mid-redirect and mid-stall.
- States: RUN and DONE.
- slot_free = !out_valid || out_ready.
- RUN, with no redirect and slot_free:
  - out_instr<=Instr, out_pc<=PC, out_valid<=1.
  - If PC == MEM_SIZE-4: stay at PC, go to DONE, done<=1.
  - Otherwise PC<=PC+4.
- RUN, with no redirect and !slot_free (stall):
  - PC, out_instr, out_pc and out_valid all hold.
  - No fetch is lost or duplicated.
- DONE:
  - No new captures; the PC holds.
  - The output slot drains normally: out_valid<=0 when out_ready==1.
  - done stays at 1 until reset or redirect.
- Redirect (redirect_en==1), in either state, highest priority after reset:
  - PC<={redirect_addr[31:2],2'b00}, out_valid<=0. The current slot is flushed even if out_ready==1, and nothing is captured this cycle.
  - If the aligned target is less than MEM_SIZE: state=RUN, done<=0.
  - If the aligned target is at or above MEM_SIZE: state=DONE, done<=1, no fetch.
- Latency:
  - An instruction at PC appears on out_instr one cycle after the PC is presented.
  - Sustained throughput is 1 instruction per cycle while out_ready==1.
- Width rules:
  - PC+4 is 32-bit unsigned.
  - Wrap-around past MEM_SIZE never occurs, because the DONE transition happens first.
- Simultaneous events:
  - Redirect and stall together: the redirect wins.
  - Handshake on the last word (PC==MEM_SIZE-4) with out_ready==1: the final capture still occurs in that cycle.

Optional Feature:
- Macro: FETCH_CNT_EN.
- When defined:
  - Adds output fetch_cnt[31:0], reset to 0.
  - Increments by 1 on every cycle where out_valid && out_ready (an accepted instruction).
  - Holds on redirect.
  - Saturates at 32'hFFFFFFFF.
- When undefined:
  - The port and its counter do not exist.
  - All other behaviour is identical.

Test Plan:
- Reset then free-run:
  - IM word at 0 is 32'h114B600B; out_ready=1.
  - Expect InstrAddr 0,4,8,… on successive cycles.
  - One cycle after reset release: out_valid=1, out_instr=32'h114B600B, out_pc=0.
- Stall:
  - Hold out_ready=0 for 3 cycles after the slot fills at out_pc=4.
  - Expect out_pc=4, out_instr and InstrAddr=8 all frozen.
  - On release, out_pc=8 is the next value, with no skip or repeat.
- End of program (MEM_SIZE=128):
  - Run to PC=124.
  - Expect a capture with out_pc=124 and done=1 in the same edge.
  - InstrAddr stays 124.
  - out_valid drops after one accept; no further captures.
- Redirect:
  - With redirect_en=1 and redirect_addr=32'h0000000E while a valid slot waits: next cycle out_valid=0 and InstrAddr=32'hC.
  - Following cycle: out_pc=32'hC.
  - redirect_addr=32'h100 gives done=1 and out_valid=0.
- Reset mid-operation:
  - Assert rst=0 during a stall at PC=20 with done=0.
  - Next edge: PC=RESET_PC, out_valid=0, done=0.
  - With FETCH_CNT_EN: fetch_cnt=0.
- FETCH_CNT_EN:
  - 5 accepted handshakes, with 2 stall cycles interleaved, then a redirect.
  - Expect fetch_cnt=5, unchanged by the redirect.
